// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Elaboration-time helpers for the parametrised Moore sequence
//                detector. Builds the KMP-style transition function and the
//                pattern border so the core can hold them as constant tables.
//                Patterns are right-aligned in a 16-bit word; the MSB of the
//                PAT_LEN-bit field is the first bit received.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_det_pkg;

    // Longest pattern the helpers support (pattern word width).
    localparam int c_MAX_PAT_LEN = 16;

    // State register width for a given pattern length (S0..S(len-1) + MATCH).
    function automatic int seq_state_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Bit i of the pattern in reception order (i = 0 is received first).
    function automatic logic seq_pat_bit(input logic [15:0] pattern,
                                         input int          len,
                                         input int          i);
        logic [15:0] v_shifted;
        v_shifted = pattern >> (len - 1 - i);
        return v_shifted[0];
    endfunction

    // Next matched length after k matched bits are followed by 'b': the longest
    // prefix of the pattern that is also a suffix of (prefix_k, b).
    function automatic int seq_delta(input logic [15:0] pattern,
                                     input int          len,
                                     input int          k,
                                     input logic        b);
        int   v_best;
        int   v_j;
        logic v_ok;
        logic v_sb;
        v_best = 0;
        for (int m = 1; m <= len; m++) begin
            if (m <= k + 1) begin
                v_ok = 1'b1;
                for (int i = 0; i < m; i++) begin
                    v_j  = k + 1 - m + i;
                    v_sb = (v_j == k) ? b : seq_pat_bit(pattern, len, v_j);
                    if (v_sb != seq_pat_bit(pattern, len, i)) begin
                        v_ok = 1'b0;
                    end
                end
                if (v_ok) begin
                    v_best = m;
                end
            end
        end
        return v_best;
    endfunction

    // Longest proper border: longest prefix that is also a suffix, shorter
    // than the whole pattern. Overlapping detection resumes from here.
    function automatic int seq_border(input logic [15:0] pattern,
                                      input int          len);
        int   v_best;
        logic v_ok;
        v_best = 0;
        for (int m = 1; m < len; m++) begin
            v_ok = 1'b1;
            for (int i = 0; i < m; i++) begin
                if (seq_pat_bit(pattern, len, i) !=
                    seq_pat_bit(pattern, len, len - m + i)) begin
                    v_ok = 1'b0;
                end
            end
            if (v_ok) begin
                v_best = m;
            end
        end
        return v_best;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_moore_param_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset (count -> 0)
//                inc  - add one this edge (ignored once all-ones)
//                clr  - synchronous clear, wins over inc
//                cnt  - current count
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/seq_detect_moore_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_moore_param
//  Description : Parametrised Moore serial-sequence detector with bit-valid
//                qualifier, runtime overlap select and saturating match count.
//  Ports       : clk       - rising-edge clock
//                rst       - synchronous active-high reset
//                en        - bit valid; FSM and counter advance only when 1
//                in        - serial data bit (first bit = PATTERN MSB)
//                overlap   - 1: reuse the pattern border after a match
//                clr_cnt   - synchronous clear of match_cnt
//                out       - high while the FSM sits in MATCH
//                state_dbg - current state index (0..PAT_LEN)
//                match_cnt - saturating number of matches
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detect_moore_param
    import seq_det_pkg::*;
#(
    parameter int                  PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0]  PATTERN = 5'b11011,
    parameter int                  CNT_W   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               in,
    input  logic                               overlap,
    input  logic                               clr_cnt,
    output logic                               out,
    output logic [$clog2(PAT_LEN+1)-1:0]       state_dbg,
    output logic [CNT_W-1:0]                   match_cnt
);

    localparam int                   c_STATE_W = seq_state_w(PAT_LEN);
    localparam int                   c_DEPTH   = 2 ** c_STATE_W;
    localparam int                   c_BORDER  = seq_border(16'(PATTERN), PAT_LEN);
    localparam logic [c_STATE_W-1:0] c_S0      = '0;
    localparam logic [c_STATE_W-1:0] c_MATCH   = c_STATE_W'(PAT_LEN);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next;
    logic                 w_inc;

    // Constant transition table, one row per encodable state. Rows at or
    // beyond PAT_LEN hold S0: MATCH is resolved separately below, and any
    // illegal encoding recovers to S0 on the next valid bit.
    logic [c_STATE_W-1:0] w_tbl [c_DEPTH][2];

    for (genvar k = 0; k < c_DEPTH; k++) begin : g_row
        if (k < PAT_LEN) begin : g_legal
            localparam int c_N0 = seq_delta(16'(PATTERN), PAT_LEN, k, 1'b0);
            localparam int c_N1 = seq_delta(16'(PATTERN), PAT_LEN, k, 1'b1);
            assign w_tbl[k][0] = c_STATE_W'(c_N0);
            assign w_tbl[k][1] = c_STATE_W'(c_N1);
        end else begin : g_illegal
            assign w_tbl[k][0] = c_S0;
            assign w_tbl[k][1] = c_S0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (en) begin
            if (r_state == c_MATCH) begin
                // From MATCH the search restarts either from the border
                // (matched tail reused) or from scratch.
                w_next = overlap ? w_tbl[c_BORDER][in] : w_tbl[0][in];
            end else begin
                w_next = w_tbl[r_state][in];
            end
        end
    end

    assign w_inc = en && (w_next == c_MATCH);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_inc),
        .clr (clr_cnt),
        .cnt (match_cnt)
    );

    assign out       = (r_state == c_MATCH);
    assign state_dbg = r_state;

endmodule
`default_nettype wire
